uart_byte_rx: RTL and testbench

//  Serial-to-byte UART receiver: 8N1 frames, LSB first, 16x oversampling per bit.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_byte_rx.sv | 103 ++++++++++
 tb/tb_uart_byte_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: oversampling divisors, frame geometry and line levels.
package uart_pkg;

  localparam logic [8:0] DR_9600   = 9'd324;
  localparam logic [8:0] DR_19200  = 9'd162;
  localparam logic [8:0] DR_38400  = 9'd80;
  localparam logic [8:0] DR_57600  = 9'd53;
  localparam logic [8:0] DR_115200 = 9'd26;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int OS_RATE    = 16;
  localparam int FRAME_SUBS = 160;

  typedef enum logic {S_IDLE = 1'b0, S_RECV = 1'b1} rx_state_t;

  // Unlisted selector codes fall back to the slowest rate.
  function automatic logic [8:0] baud_dr(input logic [2:0] sel);
    case (sel)
      3'd1:    return DR_19200;
      3'd2:    return DR_38400;
      3'd3:    return DR_57600;
      3'd4:    return DR_115200;
      default: return DR_9600;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the serial line plus a falling-edge detector.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset to the idle-high line level so release never fakes an edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling and a 6-sample majority vote per bit.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int VOTE_MIN    = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] baud_set,
  input  logic       Rs232_Rx,
  output logic [7:0] data_byte,
  output logic       Rx_Done,
  output logic       frame_err,
  output logic       uart_state
);

  localparam logic [3:0] SUB_DECIDE  = 4'd12;
  localparam logic [7:0] STOP_DECIDE = 8'(FRAME_SUBS - OS_RATE + 12);

  logic       rx_s, rx_fall;
  rx_state_t  state_q, state_d;
  logic [8:0] bps_dr, div_cnt;
  logic       bps_clk;
  logic [7:0] bps_cnt;
  logic [2:0] acc;
  logic [7:0] r_data;
  logic [3:0] sub, bit_idx;
  logic       bit_vote, false_start, frame_end;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .rx      (Rs232_Rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign sub        = bps_cnt[3:0];
  assign bit_idx    = bps_cnt[7:4];
  assign bit_vote   = (acc >= 3'(VOTE_MIN));
  assign bps_clk    = (div_cnt == 9'd1);
  assign uart_state = (state_q == S_RECV);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // The frame closes at the stop-bit centre so a following start edge is not missed.
  always_comb begin
    state_d     = state_q;
    false_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      S_IDLE: if (rx_fall) state_d = S_RECV;
      S_RECV: begin
        if (bps_clk && bps_cnt == {4'd0, SUB_DECIDE} && bit_vote != START_BIT) begin
          false_start = 1'b1;
          state_d     = S_IDLE;
        end else if (bps_clk && bps_cnt == STOP_DECIDE) begin
          frame_end = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bps_dr    <= DR_9600;
      div_cnt   <= '0;
      bps_cnt   <= '0;
      acc       <= '0;
      r_data    <= '0;
      data_byte <= '0;
      Rx_Done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bps_dr    <= baud_dr(baud_set);
      Rx_Done   <= frame_end && (bit_vote == STOP_BIT);
      frame_err <= frame_end && (bit_vote != STOP_BIT);
      if (frame_end && bit_vote == STOP_BIT) data_byte <= r_data;

      if (state_q == S_IDLE || div_cnt == bps_dr) div_cnt <= '0;
      else                                          div_cnt <= div_cnt + 9'd1;

      if (false_start || frame_end) bps_cnt <= '0;
      else if (bps_clk)             bps_cnt <= bps_cnt + 8'd1;

      if (bps_clk) begin
        if (sub == 4'd0)
          acc <= '0;
        else if (sub >= 4'd6 && sub <= 4'd11)
          acc <= acc + {2'b00, rx_s};
        if (sub == SUB_DECIDE && bit_idx >= 4'd1 && bit_idx <= 4'd8)
          r_data <= {bit_vote, r_data[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx with a byte/event scoreboard checked on every output pulse.
module tb_uart_byte_rx;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [2:0] baud_set = 3'd0;
  logic       Rs232_Rx = 1'b1;
  logic [7:0] data_byte;
  logic       Rx_Done, frame_err, uart_state;

  uart_byte_rx #(.SYNC_STAGES(2), .VOTE_MIN(4)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .baud_set   (baud_set),
    .Rs232_Rx   (Rs232_Rx),
    .data_byte  (data_byte),
    .Rx_Done    (Rx_Done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic       err;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         bit_cyc = 5200;
  logic [7:0] hold = 8'h00;
  logic       prev_pulse = 1'b0;

  // Scoreboard: every output pulse must match the next queued expectation.
  always @(negedge Clk) begin
    if (Rst_n && (Rx_Done || frame_err)) begin
      n_cmp++;
      assert (!prev_pulse) else begin
        n_bad++; $error("FAIL pulse_width observed=2+ cycles expected=1");
      end
      n_cmp++;
      assert (q.size() > 0) else begin
        n_bad++; $error("FAIL unexpected_pulse observed done=%0b err=%0b expected=none", Rx_Done, frame_err);
      end
      if (q.size() > 0) begin
        exp_t e;
        logic [7:0] want;
        e = q.pop_front();
        want = e.err ? hold : e.d;
        n_cmp++;
        assert (frame_err === e.err && Rx_Done === !e.err) else begin
          n_bad++; $error("FAIL pulse_kind observed done=%0b err=%0b expected err=%0b", Rx_Done, frame_err, e.err);
        end
        n_cmp++;
        assert (data_byte === want) else begin
          n_bad++; $error("FAIL data_byte observed=%02h expected=%02h", data_byte, want);
        end
        n_cmp++;
        assert (uart_state === 1'b0) else begin
          n_bad++; $error("FAIL state_drop observed=%0b expected=0", uart_state);
        end
        if (!e.err) hold = e.d;
      end
    end
    prev_pulse = Rst_n && (Rx_Done || frame_err);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++; $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic set_baud(input logic [2:0] s);
    int dr;
    baud_set = s;
    case (s)
      3'd1:    dr = 162;
      3'd2:    dr = 80;
      3'd3:    dr = 53;
      3'd4:    dr = 26;
      default: dr = 324;
    endcase
    bit_cyc = 16 * (dr + 1);
  endtask

  // Glitch inverts the line for one sub-sample period around the bit centre.
  task automatic drive_bit(input logic v, input bit glitch);
    int sub_cyc;
    sub_cyc = bit_cyc / 16;
    Rs232_Rx = v;
    if (glitch) begin
      wait_cyc(bit_cyc / 2 - 13);
      Rs232_Rx = ~v;
      wait_cyc(sub_cyc);
      Rs232_Rx = v;
      wait_cyc(bit_cyc - bit_cyc / 2 + 13 - sub_cyc);
    end else begin
      wait_cyc(bit_cyc);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
    drive_bit(stop, glitch);
    Rs232_Rx = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int c;
    c = 0;
    while (q.size() != 0 && c < maxc) begin
      @(negedge Clk);
      c++;
    end
    n_cmp++;
    assert (q.size() == 0) else begin
      n_bad++; $error("FAIL %s observed=%0d pending expected=0", tag, q.size());
    end
  endtask

  initial begin
    wait_cyc(3);
    check("reset_data", data_byte, 8'h00);
    check("reset_done", {7'd0, Rx_Done}, 8'h00);
    check("reset_err", {7'd0, frame_err}, 8'h00);
    check("reset_state", {7'd0, uart_state}, 8'h00);
    Rst_n = 1'b1;
    wait_cyc(5);

    set_baud(3'd0);
    wait_cyc(4);
    q.push_back('{1'b0, 8'h55});
    send_frame(8'h55, 1'b1, 1'b0);
    wait_drain("t1_drain", bit_cyc);

    set_baud(3'd4);
    wait_cyc(bit_cyc);
    q.push_back('{1'b0, 8'hA3});
    q.push_back('{1'b0, 8'h00});
    q.push_back('{1'b0, 8'hFF});
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_drain("t2_drain", bit_cyc);
    wait_cyc(bit_cyc);

    Rs232_Rx = 1'b0;
    wait_cyc(81);
    Rs232_Rx = 1'b1;
    wait_cyc(19);
    check("t3_busy", {7'd0, uart_state}, 8'h01);
    wait_cyc(300);
    check("t3_abort", {7'd0, uart_state}, 8'h00);
    wait_cyc(2 * bit_cyc);

    q.push_back('{1'b1, 8'h00});
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_drain("t4_drain", bit_cyc);
    check("t4_hold", data_byte, 8'hFF);
    wait_cyc(bit_cyc);

    q.push_back('{1'b0, 8'h81});
    send_frame(8'h81, 1'b1, 1'b1);
    wait_drain("t5_drain", bit_cyc);
    wait_cyc(bit_cyc);

    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    wait_cyc(bit_cyc / 2);
    Rst_n = 1'b0;
    #1;
    check("t6_rst_data", data_byte, 8'h00);
    check("t6_rst_done", {7'd0, Rx_Done}, 8'h00);
    check("t6_rst_err", {7'd0, frame_err}, 8'h00);
    check("t6_rst_state", {7'd0, uart_state}, 8'h00);
    hold = 8'h00;
    Rs232_Rx = 1'b1;
    wait_cyc(10);
    Rst_n = 1'b1;
    wait_cyc(bit_cyc);
    check("t6_idle", {7'd0, uart_state}, 8'h00);
    q.push_back('{1'b0, 8'h5A});
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_drain("t6_drain", bit_cyc);
    wait_cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
